scr1_ahb_mem_arb: RTL and testbench

Two-master to one-slave AHB-Lite arbiter that lets the SCR1 core's instruction (imem) and data (dmem) AHB ports share a single memory port. It sits between `scr1_top_ahb` and a single-ported memory or interconnect. Address phases that cannot issue immediately are captured in a one-entry pending buffer per master and issued later. Arbitration is fixed-priority in favour of dmem, with a starvation bound for imem.

---
 rtl/scr1_ahb_mem_arb.sv | 188 ++++++++++++++++++
 tb/tb_scr1_ahb_mem_arb.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_ahb_mem_arb.sv
// -----------------------------------------------------------------------------
// scr1_ahb_mem_arb
// Shares one AHB-Lite slave port between the SCR1 imem and dmem master ports.
// dmem has fixed priority. imem gets a turn once dmem has issued IMEM_MAX_WAIT
// times in a row while imem was waiting. A locked master keeps the port for as
// long as it keeps requesting. Address phases that cannot issue at once are
// held in a one-entry pending buffer per master.
//
// Ports
//   clk, rst_n              core clock, synchronous active-low reset
//   imem_h*                 imem master: htrans/haddr/hsize/hprot/hmastlock in,
//                           hready/hrdata/hresp out
//   dmem_h*                 dmem master: as imem, plus hwrite/hwdata in
//   mem_h*                  shared slave: address-phase controls and hwdata out,
//                           hready/hrdata/hresp in
// -----------------------------------------------------------------------------
module scr1_ahb_mem_arb #(
   parameter int unsigned IMEM_MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  imem_htrans,
   input  logic [31:0] imem_haddr,
   input  logic [2:0]  imem_hsize,
   input  logic [3:0]  imem_hprot,
   input  logic        imem_hmastlock,
   output logic        imem_hready,
   output logic [31:0] imem_hrdata,
   output logic        imem_hresp,
   input  logic [1:0]  dmem_htrans,
   input  logic [31:0] dmem_haddr,
   input  logic [2:0]  dmem_hsize,
   input  logic [3:0]  dmem_hprot,
   input  logic        dmem_hmastlock,
   input  logic        dmem_hwrite,
   input  logic [31:0] dmem_hwdata,
   output logic        dmem_hready,
   output logic [31:0] dmem_hrdata,
   output logic        dmem_hresp,
   output logic [31:0] mem_haddr,
   output logic [1:0]  mem_htrans,
   output logic [2:0]  mem_hsize,
   output logic [3:0]  mem_hprot,
   output logic [2:0]  mem_hburst,
   output logic        mem_hmastlock,
   output logic        mem_hwrite,
   output logic [31:0] mem_hwdata,
   input  logic        mem_hready,
   input  logic [31:0] mem_hrdata,
   input  logic        mem_hresp
);

   localparam logic [3:0] WAIT_MAX = 4'(IMEM_MAX_WAIT);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IMEM = 2'd1,
      OWN_DMEM = 2'd2
   } own_e;

   own_e        own;
   logic        aown_dmem;
   logic        lock_vld;
   logic        lock_dmem;
   logic [1:0]  pend_vld;   // [0] imem, [1] dmem
   logic [3:0]  wait_cnt;

   logic [31:0] ipend_addr;
   logic [2:0]  ipend_size;
   logic [3:0]  ipend_prot;
   logic        ipend_lock;
   logic [31:0] dpend_addr;
   logic [2:0]  dpend_size;
   logic [3:0]  dpend_prot;
   logic        dpend_write;
   logic        dpend_lock;

   logic        r_imem;
   logic        r_dmem;
   logic        sel_dmem;
   logic        sel_req;
   logic        issue_imem;
   logic        issue_dmem;
   logic        cap_imem;
   logic        cap_dmem;

   // A live htrans is ignored while the pending entry is valid: the master is
   // being held off with hready low and is only repeating the captured phase.
   assign r_imem = pend_vld[0] | imem_htrans[1];
   assign r_dmem = pend_vld[1] | dmem_htrans[1];

   always_comb begin
      sel_dmem = aown_dmem;
      if (mem_hready) begin
         if (lock_vld && (lock_dmem ? r_dmem : r_imem)) begin
            sel_dmem = lock_dmem;
         end else if (r_imem && r_dmem) begin
            sel_dmem = (wait_cnt != WAIT_MAX);
         end else if (r_imem) begin
            sel_dmem = 1'b0;
         end else if (r_dmem) begin
            sel_dmem = 1'b1;
         end
      end
   end

   assign sel_req    = sel_dmem ? r_dmem : r_imem;
   assign issue_imem = mem_hready & sel_req & ~sel_dmem;
   assign issue_dmem = mem_hready & sel_req &  sel_dmem;

   always_comb begin
      if (sel_dmem) begin
         mem_haddr     = pend_vld[1] ? dpend_addr  : dmem_haddr;
         mem_hsize     = pend_vld[1] ? dpend_size  : dmem_hsize;
         mem_hprot     = pend_vld[1] ? dpend_prot  : dmem_hprot;
         mem_hwrite    = pend_vld[1] ? dpend_write : dmem_hwrite;
         mem_hmastlock = pend_vld[1] ? dpend_lock  : dmem_hmastlock;
      end else begin
         mem_haddr     = pend_vld[0] ? ipend_addr  : imem_haddr;
         mem_hsize     = pend_vld[0] ? ipend_size  : imem_hsize;
         mem_hprot     = pend_vld[0] ? ipend_prot  : imem_hprot;
         mem_hwrite    = 1'b0;
         mem_hmastlock = pend_vld[0] ? ipend_lock  : imem_hmastlock;
      end
   end

   assign mem_htrans = {sel_req, 1'b0};
   assign mem_hburst = 3'b000;
   assign mem_hwdata = dmem_hwdata;

   assign imem_hready = (own == OWN_IMEM) ? mem_hready : ~pend_vld[0];
   assign dmem_hready = (own == OWN_DMEM) ? mem_hready : ~pend_vld[1];

   assign imem_hrdata = (own == OWN_IMEM) ? mem_hrdata : 32'h0;
   assign imem_hresp  = (own == OWN_IMEM) ? mem_hresp  : 1'b0;
   assign dmem_hrdata = (own == OWN_DMEM) ? mem_hrdata : 32'h0;
   assign dmem_hresp  = (own == OWN_DMEM) ? mem_hresp  : 1'b0;

   // Accepted by the master-side handshake but not taken by the slave this
   // cycle: park it so the master can move on.
   assign cap_imem = imem_htrans[1] & imem_hready & ~pend_vld[0] & ~issue_imem;
   assign cap_dmem = dmem_htrans[1] & dmem_hready & ~pend_vld[1] & ~issue_dmem;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         own       <= OWN_NONE;
         aown_dmem <= 1'b1;
         lock_vld  <= 1'b0;
         lock_dmem <= 1'b0;
         pend_vld  <= 2'b00;
         wait_cnt  <= 4'd0;
      end else begin
         if (issue_imem || issue_dmem) begin
            own       <= sel_dmem ? OWN_DMEM : OWN_IMEM;
            aown_dmem <= sel_dmem;
            lock_vld  <= mem_hmastlock;
            lock_dmem <= sel_dmem;
         end else if (mem_hready) begin
            own <= OWN_NONE;
         end
         pend_vld[0] <= cap_imem | (pend_vld[0] & ~issue_imem);
         pend_vld[1] <= cap_dmem | (pend_vld[1] & ~issue_dmem);
         if (issue_imem) begin
            wait_cnt <= 4'd0;
         end else if (issue_dmem && r_imem && (wait_cnt != WAIT_MAX)) begin
            wait_cnt <= wait_cnt + 4'd1;
         end
      end
   end

   // Pending payload is only meaningful while pend_vld is set.
   always_ff @(posedge clk) begin
      if (cap_imem) begin
         ipend_addr <= imem_haddr;
         ipend_size <= imem_hsize;
         ipend_prot <= imem_hprot;
         ipend_lock <= imem_hmastlock;
      end
      if (cap_dmem) begin
         dpend_addr  <= dmem_haddr;
         dpend_size  <= dmem_hsize;
         dpend_prot  <= dmem_hprot;
         dpend_write <= dmem_hwrite;
         dpend_lock  <= dmem_hmastlock;
      end
   end

endmodule

// File: tb/tb_scr1_ahb_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_scr1_ahb_mem_arb
// Directed bench for scr1_ahb_mem_arb with IMEM_MAX_WAIT = 4. Expected slave
// address phases ({hwrite, haddr}) are queued in issue order as stimulus is
// driven; a negedge monitor pops one per accepted slave address phase.
// -----------------------------------------------------------------------------
module tb_scr1_ahb_mem_arb;

   logic        clk;
   logic        rst_n;
   logic [1:0]  imem_htrans;
   logic [31:0] imem_haddr;
   logic [2:0]  imem_hsize;
   logic [3:0]  imem_hprot;
   logic        imem_hmastlock;
   logic        imem_hready;
   logic [31:0] imem_hrdata;
   logic        imem_hresp;
   logic [1:0]  dmem_htrans;
   logic [31:0] dmem_haddr;
   logic [2:0]  dmem_hsize;
   logic [3:0]  dmem_hprot;
   logic        dmem_hmastlock;
   logic        dmem_hwrite;
   logic [31:0] dmem_hwdata;
   logic        dmem_hready;
   logic [31:0] dmem_hrdata;
   logic        dmem_hresp;
   logic [31:0] mem_haddr;
   logic [1:0]  mem_htrans;
   logic [2:0]  mem_hsize;
   logic [3:0]  mem_hprot;
   logic [2:0]  mem_hburst;
   logic        mem_hmastlock;
   logic        mem_hwrite;
   logic [31:0] mem_hwdata;
   logic        mem_hready;
   logic [31:0] mem_hrdata;
   logic        mem_hresp;

   int n_tests = 0;
   int n_fail  = 0;
   logic [32:0] exp_q[$];

   scr1_ahb_mem_arb #(.IMEM_MAX_WAIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_htrans(imem_htrans), .imem_haddr(imem_haddr), .imem_hsize(imem_hsize),
      .imem_hprot(imem_hprot), .imem_hmastlock(imem_hmastlock),
      .imem_hready(imem_hready), .imem_hrdata(imem_hrdata), .imem_hresp(imem_hresp),
      .dmem_htrans(dmem_htrans), .dmem_haddr(dmem_haddr), .dmem_hsize(dmem_hsize),
      .dmem_hprot(dmem_hprot), .dmem_hmastlock(dmem_hmastlock),
      .dmem_hwrite(dmem_hwrite), .dmem_hwdata(dmem_hwdata),
      .dmem_hready(dmem_hready), .dmem_hrdata(dmem_hrdata), .dmem_hresp(dmem_hresp),
      .mem_haddr(mem_haddr), .mem_htrans(mem_htrans), .mem_hsize(mem_hsize),
      .mem_hprot(mem_hprot), .mem_hburst(mem_hburst), .mem_hmastlock(mem_hmastlock),
      .mem_hwrite(mem_hwrite), .mem_hwdata(mem_hwdata),
      .mem_hready(mem_hready), .mem_hrdata(mem_hrdata), .mem_hresp(mem_hresp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_masters;
      imem_htrans    = 2'b00;
      imem_hmastlock = 1'b0;
      dmem_htrans    = 2'b00;
      dmem_hmastlock = 1'b0;
      dmem_hwrite    = 1'b0;
   endtask

   // Slave-side scoreboard and ownership invariant, sampled mid-cycle.
   always @(negedge clk) begin
      logic [32:0] e;
      if (rst_n) begin
         n_tests++;
         assert (!((dut.pend_vld[0] && dut.own == 2'd1) || (dut.pend_vld[1] && dut.own == 2'd2)))
         else begin
            n_fail++;
            $error("FAIL invariant: observed pend_vld %b own %0d expected no overlap",
                   dut.pend_vld, dut.own);
         end
         if (mem_htrans[1] && mem_hready) begin
            n_tests++;
            assert (exp_q.size() > 0) else begin
               n_fail++;
               $error("FAIL sb_unexpected: observed issue %h expected none", {mem_hwrite, mem_haddr});
            end
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               n_tests++;
               assert ({mem_hwrite, mem_haddr} === e) else begin
                  n_fail++;
                  $error("FAIL sb_issue: observed %h expected %h", {mem_hwrite, mem_haddr}, e);
               end
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      idle_masters();
      imem_haddr = '0; imem_hsize = 3'd2; imem_hprot = 4'h3;
      dmem_haddr = '0; dmem_hsize = 3'd2; dmem_hprot = 4'h1; dmem_hwdata = '0;
      mem_hready = 1'b1; mem_hrdata = '0; mem_hresp = 1'b0;

      // ---------------- power-on reset ----------------
      tick(); tick();
      rst_n = 1'b1;
      #1;
      chk("rst_htrans", 32'(mem_htrans), 32'd0);
      chk("rst_hburst", 32'(mem_hburst), 32'd0);
      chk("rst_ihready", 32'(imem_hready), 32'd1);
      chk("rst_dhready", 32'(dmem_hready), 32'd1);

      // ---------------- lone imem read ----------------
      tick();
      imem_htrans = 2'b10; imem_haddr = 32'h200;
      exp_q.push_back({1'b0, 32'h200});
      #1;
      chk("lone_haddr", mem_haddr, 32'h200);
      chk("lone_htrans", 32'(mem_htrans), 32'd2);
      chk("lone_hburst", 32'(mem_hburst), 32'd0);
      tick();
      idle_masters();
      mem_hrdata = 32'hDEADBEEF;
      #1;
      chk("lone_irdata", imem_hrdata, 32'hDEADBEEF);
      chk("lone_ihready", 32'(imem_hready), 32'd1);
      chk("lone_drdata", dmem_hrdata, 32'h0);
      chk("lone_idle", 32'(mem_htrans), 32'd0);
      tick();
      mem_hrdata = '0;

      // ---------------- simultaneous requests ----------------
      tick();
      imem_htrans = 2'b10; imem_haddr = 32'h100;
      dmem_htrans = 2'b10; dmem_haddr = 32'h8000; dmem_hwrite = 1'b1;
      exp_q.push_back({1'b1, 32'h8000});
      exp_q.push_back({1'b0, 32'h100});
      #1;
      chk("sim_c0_haddr", mem_haddr, 32'h8000);
      chk("sim_c0_hwrite", 32'(mem_hwrite), 32'd1);
      chk("sim_c0_ihready", 32'(imem_hready), 32'd1);
      tick();
      idle_masters();
      dmem_hwdata = 32'h55;
      #1;
      chk("sim_c1_hwdata", mem_hwdata, 32'h55);
      chk("sim_c1_haddr", mem_haddr, 32'h100);
      chk("sim_c1_htrans", 32'(mem_htrans), 32'd2);
      chk("sim_c1_ihready", 32'(imem_hready), 32'd0);
      chk("sim_c1_dhready", 32'(dmem_hready), 32'd1);
      tick();
      mem_hrdata = 32'h12345678;
      #1;
      chk("sim_c2_ihready", 32'(imem_hready), 32'd1);
      chk("sim_c2_irdata", imem_hrdata, 32'h12345678);
      chk("sim_c2_drdata", dmem_hrdata, 32'h0);
      chk("sim_c2_waitcnt", 32'(dut.wait_cnt), 32'd0);
      tick();
      mem_hrdata = '0;

      // ---------------- starvation bound ----------------
      tick();
      imem_htrans = 2'b10; imem_haddr = 32'h300;
      dmem_htrans = 2'b10; dmem_haddr = 32'h9000; dmem_hwrite = 1'b0;
      exp_q.push_back({1'b0, 32'h9000});
      #1;
      chk("stv_c0_haddr", mem_haddr, 32'h9000);
      for (int i = 1; i <= 3; i++) begin
         tick();
         imem_htrans = 2'b00;
         dmem_haddr = 32'h9000 + 32'(4 * i);
         exp_q.push_back({1'b0, dmem_haddr});
         #1;
         chk("stv_ihready", 32'(imem_hready), 32'd0);
         chk("stv_dhready", 32'(dmem_hready), 32'd1);
         chk("stv_waitcnt", 32'(dut.wait_cnt), 32'(i));
      end
      tick();
      dmem_haddr = 32'h9010;
      exp_q.push_back({1'b0, 32'h300});
      exp_q.push_back({1'b0, 32'h9010});
      #1;
      chk("stv_imem_turn", mem_haddr, 32'h300);
      chk("stv_waitcnt_max", 32'(dut.wait_cnt), 32'd4);
      tick();
      idle_masters();
      #1;
      chk("stv_waitcnt_clr", 32'(dut.wait_cnt), 32'd0);
      chk("stv_dpend_hready", 32'(dmem_hready), 32'd0);
      chk("stv_dpend_haddr", mem_haddr, 32'h9010);
      tick();
      #1;
      chk("stv_dhready_end", 32'(dmem_hready), 32'd1);
      tick();

      // ---------------- error response ----------------
      tick();
      dmem_htrans = 2'b10; dmem_haddr = 32'hA000;
      imem_htrans = 2'b10; imem_haddr = 32'h400;
      exp_q.push_back({1'b0, 32'hA000});
      exp_q.push_back({1'b0, 32'h400});
      #1;
      chk("err_c0_haddr", mem_haddr, 32'hA000);
      tick();
      idle_masters();
      mem_hready = 1'b0; mem_hresp = 1'b1;
      #1;
      chk("err_c1_dhready", 32'(dmem_hready), 32'd0);
      chk("err_c1_dhresp", 32'(dmem_hresp), 32'd1);
      chk("err_c1_ihresp", 32'(imem_hresp), 32'd0);
      chk("err_c1_ihready", 32'(imem_hready), 32'd0);
      chk("err_c1_pend", 32'(dut.pend_vld), 32'd1);
      chk("err_c1_htrans", 32'(mem_htrans), 32'd0);
      tick();
      mem_hready = 1'b1;
      #1;
      chk("err_c2_dhready", 32'(dmem_hready), 32'd1);
      chk("err_c2_dhresp", 32'(dmem_hresp), 32'd1);
      chk("err_c2_ihresp", 32'(imem_hresp), 32'd0);
      chk("err_c2_haddr", mem_haddr, 32'h400);
      chk("err_c2_htrans", 32'(mem_htrans), 32'd2);
      tick();
      mem_hresp = 1'b0; mem_hrdata = 32'hCAFE0001;
      #1;
      chk("err_c3_irdata", imem_hrdata, 32'hCAFE0001);
      chk("err_c3_ihready", 32'(imem_hready), 32'd1);
      chk("err_c3_dhresp", 32'(dmem_hresp), 32'd0);
      tick();
      mem_hrdata = '0;

      // ---------------- lock hold (also overrides the starvation turn) ----------------
      tick();
      dmem_htrans = 2'b10; dmem_haddr = 32'hB000; dmem_hmastlock = 1'b1;
      imem_htrans = 2'b10; imem_haddr = 32'h500;
      exp_q.push_back({1'b0, 32'hB000});
      #1;
      chk("lck_c0_hmastlock", 32'(mem_hmastlock), 32'd1);
      chk("lck_c0_haddr", mem_haddr, 32'hB000);
      for (int i = 1; i <= 4; i++) begin
         tick();
         imem_htrans = 2'b00;
         dmem_haddr = 32'hB000 + 32'(4 * i);
         dmem_hmastlock = (i < 4);
         exp_q.push_back({1'b0, dmem_haddr});
         #1;
         chk("lck_ihready", 32'(imem_hready), 32'd0);
         chk("lck_haddr", mem_haddr, dmem_haddr);
      end
      chk("lck_waitcnt_max", 32'(dut.wait_cnt), 32'd4);
      tick();
      idle_masters();
      exp_q.push_back({1'b0, 32'h500});
      #1;
      chk("lck_imem_haddr", mem_haddr, 32'h500);
      chk("lck_imem_lock", 32'(mem_hmastlock), 32'd0);
      tick();
      #1;
      chk("lck_ihready_end", 32'(imem_hready), 32'd1);
      chk("lck_waitcnt_clr", 32'(dut.wait_cnt), 32'd0);
      tick();

      // ---------------- reset while dmem is pending ----------------
      tick();
      imem_htrans = 2'b10; imem_haddr = 32'h600;
      exp_q.push_back({1'b0, 32'h600});
      #1;
      chk("rsp_c0_htrans", 32'(mem_htrans), 32'd2);
      tick();
      idle_masters();
      mem_hready = 1'b0;
      dmem_htrans = 2'b10; dmem_haddr = 32'hC000; dmem_hwrite = 1'b1;
      #1;
      chk("rsp_c1_dhready", 32'(dmem_hready), 32'd1);
      chk("rsp_c1_ihready", 32'(imem_hready), 32'd0);
      tick();
      idle_masters();
      rst_n = 1'b0;
      #1;
      chk("rsp_c2_dhready", 32'(dmem_hready), 32'd0);
      chk("rsp_c2_pend", 32'(dut.pend_vld), 32'd2);
      chk("rsp_c2_htrans", 32'(mem_htrans), 32'd0);
      tick();
      rst_n = 1'b1;
      mem_hready = 1'b1;
      #1;
      chk("rsp_htrans", 32'(mem_htrans), 32'd0);
      chk("rsp_hburst", 32'(mem_hburst), 32'd0);
      chk("rsp_dhready", 32'(dmem_hready), 32'd1);
      chk("rsp_ihready", 32'(imem_hready), 32'd1);
      chk("rsp_pend", 32'(dut.pend_vld), 32'd0);
      chk("rsp_own", 32'(dut.own), 32'd0);
      chk("rsp_waitcnt", 32'(dut.wait_cnt), 32'd0);
      chk("rsp_ihresp", 32'(imem_hresp), 32'd0);
      chk("rsp_dhresp", 32'(dmem_hresp), 32'd0);

      tick(); tick();
      chk("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
